// File: rtl/vram_fetch_arbiter.sv
// Shared video RAM sequencer: raster timing, per-group video fetch, CPU slot arbitration.
// Optional interrupt generator: define VRAM_IRQ_GEN_EN.
module vram_fetch_arbiter #(
    parameter int          H_TOTAL   = 320,
    parameter int          H_ACTIVE  = 256,
    parameter int          V_TOTAL   = 262,
    parameter int          V_ACTIVE  = 224,
    parameter int          HS_START  = 272,
    parameter int          HS_END    = 304,
    parameter int          VS_START  = 236,
    parameter int          VS_END    = 240,
    parameter logic [15:0] VRAM_BASE = 16'h2400
) (
    input  logic        c,
    input  logic        r,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    output logic [15:0] ram_addr,
    output logic        ram_cpu_sel,
    output logic        ram_we,
    output logic        vid_latch,
    output logic        sr_ld_n,
    output logic        cpu_ack,
    output logic [8:0]  hcnt,
    output logic [8:0]  vcnt,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync_n,
    output logic        vsync_n
`ifdef VRAM_IRQ_GEN_EN
    ,
    output logic        irq_mid,
    output logic        irq_vbl,
    output logic [7:0]  irq_vec
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
    localparam logic [8:0] HS_S   = 9'(HS_START);
    localparam logic [8:0] HS_E   = 9'(HS_END);
    localparam logic [8:0] VS_S   = 9'(VS_START);
    localparam logic [8:0] VS_E   = 9'(VS_END);
    localparam logic [5:0] G_FEND = 6'(H_ACTIVE / 8 - 1);
    localparam logic [5:0] G_LAST = 6'(H_TOTAL / 8 - 1);

    logic [8:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic        ram_cpu_sel_q, ram_cpu_sel_d;
    logic        ram_we_q, ram_we_d;
    logic        vid_latch_q, vid_latch_d;
    logic        sr_ld_n_q, sr_ld_n_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        hblank_q, hblank_d, vblank_q, vblank_d;
    logic        hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;

    logic [5:0]  grp, f_col;
    logic [2:0]  ph;
    logic [8:0]  nxt_line, f_line;
    logic [15:0] f_addr;
    logic        fetch, slot_free;

    // Everything is decoded from the next counter value so that the
    // registered outputs line up with the registered hcnt/vcnt.
    always_comb begin
        hcnt_d = (hcnt_q == H_LAST) ? 9'd0 : hcnt_q + 9'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST)
            vcnt_d = (vcnt_q == V_LAST) ? 9'd0 : vcnt_q + 9'd1;

        grp      = hcnt_d[8:3];
        ph       = hcnt_d[2:0];
        nxt_line = (vcnt_d == V_LAST) ? 9'd0 : vcnt_d + 9'd1;
        fetch    = 1'b0;
        f_line   = vcnt_d;
        f_col    = grp + 6'd1;
        if (grp < G_FEND && vcnt_d < V_ACT) begin
            fetch = 1'b1;
        end else if (grp == G_LAST && nxt_line < V_ACT) begin
            fetch  = 1'b1;
            f_line = nxt_line;
            f_col  = 6'd0;
        end
        f_addr = VRAM_BASE + {2'b00, f_line, 5'b00000} + {10'd0, f_col};

        // ACC plus ACK must both avoid p4/p5 of a fetch group.
        slot_free = !(fetch && (ph == 3'd3 || ph == 3'd4 || ph == 3'd5));

        case (state_q)
            S_IDLE:  state_d = (cpu_req && slot_free) ? S_ACC : S_IDLE;
            S_ACC:   state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ram_cpu_sel_d = (state_d != S_IDLE);
        ram_we_d      = (state_d == S_ACC) && cpu_we;
        cpu_ack_d     = (state_d == S_ACK);

        ram_addr_d = ram_addr_q;
        if (state_d == S_ACC)
            ram_addr_d = cpu_addr;
        else if (fetch && (ph == 3'd4 || ph == 3'd5))
            ram_addr_d = f_addr;

        vid_latch_d = fetch && (ph == 3'd5);
        sr_ld_n_d   = !(fetch && (ph == 3'd7));
        hblank_d    = (hcnt_d >= H_ACT);
        vblank_d    = (vcnt_d >= V_ACT);
        hsync_n_d   = !(hcnt_d >= HS_S && hcnt_d < HS_E);
        vsync_n_d   = !(vcnt_d >= VS_S && vcnt_d < VS_E);
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            hcnt_q        <= 9'd0;
            vcnt_q        <= 9'd0;
            state_q       <= S_IDLE;
            ram_addr_q    <= VRAM_BASE;
            ram_cpu_sel_q <= 1'b0;
            ram_we_q      <= 1'b0;
            vid_latch_q   <= 1'b0;
            sr_ld_n_q     <= 1'b1;
            cpu_ack_q     <= 1'b0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            state_q       <= state_d;
            ram_addr_q    <= ram_addr_d;
            ram_cpu_sel_q <= ram_cpu_sel_d;
            ram_we_q      <= ram_we_d;
            vid_latch_q   <= vid_latch_d;
            sr_ld_n_q     <= sr_ld_n_d;
            cpu_ack_q     <= cpu_ack_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
        end
    end

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign ram_addr    = ram_addr_q;
    assign ram_cpu_sel = ram_cpu_sel_q;
    assign ram_we      = ram_we_q;
    assign vid_latch   = vid_latch_q;
    assign sr_ld_n     = sr_ld_n_q;
    assign cpu_ack     = cpu_ack_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;

`ifdef VRAM_IRQ_GEN_EN
    localparam logic [8:0] V_MID = 9'd96;

    logic       irq_mid_q, irq_mid_d, irq_vbl_q, irq_vbl_d;
    logic [7:0] irq_vec_q, irq_vec_d;

    always_comb begin
        irq_mid_d = (hcnt_d == 9'd0) && (vcnt_d == V_MID);
        irq_vbl_d = (hcnt_d == 9'd0) && (vcnt_d == V_ACT);
        irq_vec_d = irq_vec_q;
        if (irq_mid_d)
            irq_vec_d = 8'hCF;
        else if (irq_vbl_d)
            irq_vec_d = 8'hD7;
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            irq_mid_q <= 1'b0;
            irq_vbl_q <= 1'b0;
            irq_vec_q <= 8'h00;
        end else begin
            irq_mid_q <= irq_mid_d;
            irq_vbl_q <= irq_vbl_d;
            irq_vec_q <= irq_vec_d;
        end
    end

    assign irq_mid = irq_mid_q;
    assign irq_vbl = irq_vbl_q;
    assign irq_vec = irq_vec_q;
`endif

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Scoreboard bench for vram_fetch_arbiter: raster model, fetch and CPU queues.
// Covers the VRAM_IRQ_GEN_EN outputs when that macro is defined.
module tb_vram_fetch_arbiter;

    logic        c, r, cpu_req, cpu_we;
    logic [15:0] cpu_addr, ram_addr;
    logic        ram_cpu_sel, ram_we, vid_latch, sr_ld_n, cpu_ack;
    logic [8:0]  hcnt, vcnt;
    logic        hblank, vblank, hsync_n, vsync_n;
`ifdef VRAM_IRQ_GEN_EN
    logic        irq_mid, irq_vbl;
    logic [7:0]  irq_vec;
    int          n_mid, n_vbl;
`endif

    int n_chk = 0;
    int n_bad = 0;

    vram_fetch_arbiter dut (
        .c(c), .r(r), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .ram_addr(ram_addr),
        .ram_cpu_sel(ram_cpu_sel), .ram_we(ram_we),
        .vid_latch(vid_latch), .sr_ld_n(sr_ld_n), .cpu_ack(cpu_ack),
        .hcnt(hcnt), .vcnt(vcnt), .hblank(hblank), .vblank(vblank),
        .hsync_n(hsync_n), .vsync_n(vsync_n)
`ifdef VRAM_IRQ_GEN_EN
        , .irq_mid(irq_mid), .irq_vbl(irq_vbl), .irq_vec(irq_vec)
`endif
    );

    typedef struct {
        logic [8:0]  v, h;
        logic [15:0] addr;
        logic        chk_addr, latch, ldn;
    } fetch_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [8:0]  v, h;
    } acc_t;

    fetch_t fq[$];
    acc_t   aq[$];
    logic [8:0] mh, mv;

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at v=%0d h=%0d",
                     nm, act, exp, vcnt, hcnt);
        end
    endtask

    function automatic logic fg(input logic [8:0] v, input logic [5:0] g);
        logic [8:0] nl;
        nl = (v == 9'd261) ? 9'd0 : v + 9'd1;
        if (v < 9'd224 && g < 6'd31) return 1'b1;
        if (g == 6'd39 && nl < 9'd224) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge c or negedge r) begin
        if (!r) begin
            mh <= 9'd0;
            mv <= 9'd0;
        end else if (mh == 9'd319) begin
            mh <= 9'd0;
            mv <= (mv == 9'd261) ? 9'd0 : mv + 9'd1;
        end else begin
            mh <= mh + 9'd1;
        end
    end

    // raster and pixel-path monitor
    always @(negedge c) begin
        if (r) begin
            chk("hcnt", 32'(hcnt), 32'(mh));
            chk("vcnt", 32'(vcnt), 32'(mv));
            chk("hblank", 32'(hblank), 32'(mh >= 9'd256));
            chk("vblank", 32'(vblank), 32'(mv >= 9'd224));
            chk("hsync_n", 32'(hsync_n), 32'(!(mh >= 9'd272 && mh < 9'd304)));
            chk("vsync_n", 32'(vsync_n), 32'(!(mv >= 9'd236 && mv < 9'd240)));
            chk("vid_latch", 32'(vid_latch),
                32'(fg(mv, mh[8:3]) && mh[2:0] == 3'd5));
            chk("sr_ld_n", 32'(sr_ld_n),
                32'(!(fg(mv, mh[8:3]) && mh[2:0] == 3'd7)));
            chk("cpu_in_fetch", 32'(ram_cpu_sel && fg(mv, mh[8:3]) &&
                (mh[2:0] == 3'd4 || mh[2:0] == 3'd5)), 32'd0);
            if (fq.size() > 0 && vcnt == fq[0].v && hcnt == fq[0].h) begin
                if (fq[0].chk_addr)
                    chk("fetch_addr", 32'(ram_addr), 32'(fq[0].addr));
                chk("fetch_latch", 32'(vid_latch), 32'(fq[0].latch));
                chk("fetch_ldn", 32'(sr_ld_n), 32'(fq[0].ldn));
                chk("fetch_sel", 32'(ram_cpu_sel), 32'd0);
                void'(fq.pop_front());
            end
        end
    end

    // CPU access scoreboard
    always @(negedge c) begin
        if (r && ram_cpu_sel && !cpu_ack) begin
            if (aq.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL acc_unexpected actual=1 required=0");
            end else begin
                chk("acc_addr", 32'(ram_addr), 32'(aq[0].addr));
                chk("acc_we", 32'(ram_we), 32'(aq[0].we));
                chk("acc_pos", 32'({vcnt, hcnt}),
                    32'({aq[0].v, aq[0].h - 9'd1}));
            end
        end
        if (r && cpu_ack) begin
            if (aq.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL ack_unexpected actual=1 required=0");
            end else begin
                chk("ack_pos", 32'({vcnt, hcnt}), 32'({aq[0].v, aq[0].h}));
                chk("ack_sel", 32'(ram_cpu_sel), 32'd1);
                chk("ack_we", 32'(ram_we), 32'd0);
                void'(aq.pop_front());
            end
        end
    end

`ifdef VRAM_IRQ_GEN_EN
    always @(negedge c) begin
        if (r && irq_mid) begin
            n_mid++;
            chk("irq_mid_pos", 32'({vcnt, hcnt}), 32'({9'd96, 9'd0}));
            chk("irq_mid_vec", 32'(irq_vec), 32'h0CF);
        end
        if (r && irq_vbl) begin
            n_vbl++;
            chk("irq_vbl_pos", 32'({vcnt, hcnt}), 32'({9'd224, 9'd0}));
            chk("irq_vbl_vec", 32'(irq_vec), 32'h0D7);
        end
    end
`endif

    task automatic reset_vals();
        chk("rst_hcnt", 32'(hcnt), 32'd0);
        chk("rst_vcnt", 32'(vcnt), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'h2400);
        chk("rst_sel", 32'(ram_cpu_sel), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_latch", 32'(vid_latch), 32'd0);
        chk("rst_ldn", 32'(sr_ld_n), 32'd1);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_hsync", 32'(hsync_n), 32'd1);
        chk("rst_vsync", 32'(vsync_n), 32'd1);
        chk("rst_hblank", 32'(hblank), 32'd0);
        chk("rst_vblank", 32'(vblank), 32'd0);
`ifdef VRAM_IRQ_GEN_EN
        chk("rst_irq_mid", 32'(irq_mid), 32'd0);
        chk("rst_irq_vbl", 32'(irq_vbl), 32'd0);
        chk("rst_irq_vec", 32'(irq_vec), 32'd0);
`endif
    endtask

    task automatic wait_pos(input logic [8:0] v, input logic [8:0] h);
        int n = 0;
        do begin
            @(negedge c);
            n++;
        end while (!(vcnt == v && hcnt == h) && n < 90000);
        chk("wait_pos", 32'({vcnt, hcnt}), 32'({v, h}));
    endtask

    task automatic cpu_run(input logic [15:0] a, input logic w, input int n);
        cpu_addr = a;
        cpu_we   = w;
        cpu_req  = 1'b1;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin
                @(negedge c);
                t++;
            end while (!cpu_ack && t < 20);
            chk("ack_seen", 32'(cpu_ack), 32'd1);
            cpu_addr = a + 16'(k + 1);
        end
        cpu_req = 1'b0;
    endtask

    task automatic push_f(input logic [8:0] v, input logic [8:0] h,
                          input logic [15:0] a, input logic ca,
                          input logic l, input logic ld);
        fq.push_back('{v: v, h: h, addr: a, chk_addr: ca, latch: l, ldn: ld});
    endtask

    task automatic push_a(input logic [15:0] a, input logic w,
                          input logic [8:0] v, input logic [8:0] h);
        aq.push_back('{addr: a, we: w, v: v, h: h});
    endtask

    initial begin
`ifdef VRAM_IRQ_GEN_EN
        n_mid = 0;
        n_vbl = 0;
`endif
        r        = 1'b0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        repeat (3) @(negedge c);
        #1 reset_vals();
        #1 r = 1'b1;

        wait_pos(9'd0, 9'd100);
        #2 r = 1'b0;
        #1 reset_vals();
        @(negedge c);
        #2 r = 1'b1;
        #1 chk("rel_h0", 32'(hcnt), 32'd0);
        @(posedge c);
        #1 chk("rel_h1", 32'(hcnt), 32'd1);
        @(posedge c);
        #1 chk("rel_h2", 32'(hcnt), 32'd2);
`ifdef VRAM_IRQ_GEN_EN
        n_mid = 0;
        n_vbl = 0;
`endif

        push_f(9'd5,   9'd28,  16'h24A4, 1'b1, 1'b0, 1'b1);
        push_f(9'd5,   9'd29,  16'h24A4, 1'b1, 1'b1, 1'b1);
        push_f(9'd5,   9'd31,  16'h0000, 1'b0, 1'b0, 1'b0);
        push_f(9'd5,   9'd247, 16'h0000, 1'b0, 1'b0, 1'b0);
        push_f(9'd5,   9'd255, 16'h0000, 1'b0, 1'b0, 1'b1);
        push_f(9'd5,   9'd287, 16'h0000, 1'b0, 1'b0, 1'b1);
        push_f(9'd5,   9'd316, 16'h24C0, 1'b1, 1'b0, 1'b1);
        push_f(9'd5,   9'd317, 16'h24C0, 1'b1, 1'b1, 1'b1);
        push_f(9'd5,   9'd319, 16'h0000, 1'b0, 1'b0, 1'b0);
        push_f(9'd223, 9'd319, 16'h0000, 1'b0, 1'b0, 1'b1);
        push_f(9'd224, 9'd29,  16'h0000, 1'b0, 1'b0, 1'b1);
        push_f(9'd261, 9'd316, 16'h2400, 1'b1, 1'b0, 1'b1);
        push_f(9'd261, 9'd317, 16'h2400, 1'b1, 1'b1, 1'b1);

        wait_pos(9'd0, 9'd319);
        @(posedge c);
        #1 chk("hwrap", 32'({vcnt, hcnt}), 32'({9'd1, 9'd0}));

        wait_pos(9'd6, 9'd27);
        push_a(16'h2500, 1'b1, 9'd6, 9'd31);
        cpu_run(16'h2500, 1'b1, 1);

        wait_pos(9'd7, 9'd26);
        push_a(16'h2600, 1'b0, 9'd7, 9'd31);
        cpu_run(16'h2600, 1'b0, 1);

        wait_pos(9'd8, 9'd25);
        push_a(16'h2601, 1'b0, 9'd8, 9'd27);
        cpu_run(16'h2601, 1'b0, 1);

        wait_pos(9'd230, 9'd10);
        push_a(16'h2410, 1'b0, 9'd230, 9'd12);
        push_a(16'h2411, 1'b0, 9'd230, 9'd15);
        push_a(16'h2412, 1'b0, 9'd230, 9'd18);
        cpu_run(16'h2410, 1'b0, 3);

        wait_pos(9'd261, 9'd319);
        @(posedge c);
        #1 chk("vwrap", 32'({vcnt, hcnt}), 32'({9'd0, 9'd0}));
        repeat (4) @(negedge c);

        chk("fetch_q_left", 32'(fq.size()), 32'd0);
        chk("acc_q_left", 32'(aq.size()), 32'd0);
`ifdef VRAM_IRQ_GEN_EN
        chk("irq_mid_count", 32'(n_mid), 32'd1);
        chk("irq_vbl_count", 32'(n_vbl), 32'd1);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_fetch_arbiter.md
Name: vram_fetch_arbiter

Overview:
- Sequences the shared video RAM between the 8080-side CPU bus and the video serializer (parallel-load shift register fed through 2-input address muxes).
- Generates raster counters and syncs, schedules one video byte fetch per 8-pixel group, and grants the CPU the remaining RAM slots through a request/acknowledge handshake.
- Drives the mux select, RAM write strobe, shift-register SH/LD and latch strobes; sits between CPU bus logic and the pixel path.

Parameters:
- H_TOTAL, 320, pixel clocks per line (multiple of 8)
- H_ACTIVE, 256, visible pixels per line (multiple of 8)
- V_TOTAL, 262, lines per frame
- V_ACTIVE, 224, visible lines
- HS_START, 272, hcnt at which hsync_n falls; HS_END, 304, hcnt at which it rises
- VS_START, 236, vcnt at which vsync_n falls; VS_END, 240, vcnt at which it rises
- VRAM_BASE, 16'h2400, byte address of line 0 column 0

Ports:
- c  input  1  pixel clock, all state on rising edge
- r  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access request, level, held until cpu_ack
- cpu_we  input  1  1 = write, sampled with cpu_req
- cpu_addr  input  16  CPU byte address
- ram_addr  output  16  address to RAM (muxed)
- ram_cpu_sel  output  1  1 = CPU owns RAM (drives mux S)
- ram_we  output  1  RAM write strobe, active high
- vid_latch  output  1  one-cycle strobe: capture RAM data into video holding register
- sr_ld_n  output  1  shift-register SH/LD, 0 = parallel load on next edge
- cpu_ack  output  1  one-cycle access-complete pulse
- hcnt  output  9  horizontal counter; vcnt  output  9  vertical counter
- hblank, vblank  output  1 each  blanking flags
- hsync_n, vsync_n  output  1 each  active-low syncs

Behaviour:
- Reset (r=0, async): hcnt=vcnt=0, FSM=IDLE, ram_cpu_sel=0, ram_we=0, vid_latch=0, sr_ld_n=1, cpu_ack=0, hsync_n=vsync_n=1, ram_addr=VRAM_BASE. Reset mid-access aborts it with no ack; CPU must re-request.
- Counters: hcnt 0..H_TOTAL-1 wraps to 0, incrementing vcnt; vcnt wraps at V_TOTAL-1. hblank = hcnt>=H_ACTIVE; vblank = vcnt>=V_ACTIVE; syncs low for [START,END). All outputs registered.
- Group g = hcnt[8:3], phase p = hcnt[2:0].
- Fetch group: g < H_ACTIVE/8-1 with vcnt<V_ACTIVE fetches column g+1 of line vcnt; g = H_TOTAL/8-1 fetches column 0 of line (vcnt+1) mod V_TOTAL if that line < V_ACTIVE. Address = VRAM_BASE + line*32 + column.
- In a fetch group: p=4,5 video owns RAM (ram_cpu_sel=0, ram_we=0); vid_latch=1 at p=5; sr_ld_n=0 at p=7 (load at 7->0 edge). Result: byte for column k is shifted starting at first pixel of group k. Non-fetch groups: sr_ld_n stays 1.
- CPU FSM states IDLE, ACC, ACK:
  - IDLE->ACC when cpu_req=1 and slot free: in fetch group p in {0,1,2}, or p in {6,7} being any; in non-fetch group any p except 7 of a group followed by a fetch group's p0 is fine (no conflict). Rule: an access occupies two cycles and must not overlap p=4,5 of a fetch group.
  - ACC: ram_cpu_sel=1, ram_addr=cpu_addr, ram_we=cpu_we; 1 cycle -> ACK.
  - ACK: ram_cpu_sel=1, ram_we=0, cpu_ack=1 for one cycle -> IDLE. Next request may start the cycle after ACK.
- Priority: video always wins; CPU is deferred, never preempted. cpu_addr/cpu_we must be stable while cpu_req=1.
- Worst-case CPU latency request->ack: 6 cycles.

Optional Feature:
- Macro VRAM_IRQ_GEN_EN. When defined: outputs irq_mid and irq_vbl (1 bit each, reset 0) pulse one cycle at hcnt=0 of vcnt=96 and vcnt=V_ACTIVE respectively; plus irq_vec (8 bit) = 8'hCF for mid, 8'hD7 for vblank, held until next pulse, reset 8'h00. When undefined: ports absent, no logic.

Test Plan:
- Reset asserted at hcnt=100 -> all outputs at reset values immediately; after release hcnt counts 0,1,2 on successive edges.
- Free-run one frame -> hcnt wraps at 319, vcnt wraps at 261; hsync_n low exactly hcnt 272..303; vsync_n low vcnt 236..239.
- Line vcnt=5, group g=3 -> ram_addr=16'h24A4 at p=4,5, vid_latch at p=5, sr_ld_n=0 at p=7; g=39 on vcnt=5 -> addr 16'h24C0.
- cpu_req write addr 16'h2500 raised at p=3 of fetch group -> ACC at p=6, ram_we=1 one cycle, cpu_ack at p=7; ram_cpu_sel never 1 at p=4,5.
- cpu_req during vblank, back-to-back reads -> each completes in 2 cycles, ack every 3 cycles, no video fetch.
- With VRAM_IRQ_GEN_EN: irq_mid at (hcnt 0, vcnt 96) with irq_vec=8'hCF; irq_vbl at vcnt 224 with 8'hD7; exactly one pulse each per frame.
